matrix_square_engine: RTL and testbench
=======================================

# matrix_square_engine

Iterative fixed-point matrix-squaring engine that produces the successive powers M, M², M⁴, … of an N_STOCKS×N_STOCKS signed Q5.10 matrix. It drives its `matrix_out` onto the input of the existing `converge` checker and consumes that checker's combinational `conv` flag. It stops when the checker reports convergence or when an iteration cap is reached. It is the producer side of the matrix/conv interface that `converge` terminates.

## Interface
- N_STOCKS, 2, matrix dimension (N).
- WIDTH, 16, element width, signed two's complement.
- FRAC, 10, fractional bits; 1.0 = 1024.
- MAX_ITER, 16, maximum squaring iterations before giving up.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- matrix_in  input  [N-1:0][N-1:0] × WIDTH signed  initial matrix, sampled in LOAD.
- conv_in  input  1  `conv` output of `converge`, fed combinationally from matrix_out.
- matrix_out  output  [N-1:0][N-1:0] × WIDTH signed  current working matrix.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of run.
- converged  output  1  result of last run; valid from done, held until next accepted start.
- iter_count  output  $clog2(MAX_ITER+1)  squarings completed in current/last run.

## Operation
- States: IDLE, LOAD, CHECK, MAC, WRITE, DONE.
- IDLE: start=1 → LOAD; clear converged, iter_count.
- LOAD: matrix_out ← matrix_in → CHECK.
- CHECK: sample conv_in. If 1 → DONE with converged=1. Else if iter_count==MAX_ITER → DONE with converged=0. Else → MAC.
- MAC: indices i, j, k, row-major, k innermost; one product per cycle; N³ cycles.
  - acc += matrix_out[i][k]·matrix_out[k][j].
  - At k==N-1, write the rounded result to B[i][j] and clear acc.
- WRITE: matrix_out ← B; iter_count++ → CHECK.
- DONE: done=1 for this cycle only → IDLE.
- Arithmetic:
  - Products are full 2·WIDTH bits.
  - Accumulator is 2·WIDTH+$clog2(N) bits, so it never overflows.
  - Result = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift (round half up), then reduced to WIDTH bits (see Configuration).
- start while busy is ignored. matrix_in changes outside LOAD have no effect.
- matrix_out holds its value in IDLE and DONE. The last matrix stays visible after done.
- Reset (asynchronous, any state, including mid-MAC):
  - Go to IDLE; matrix_out, B and acc are 0.
  - busy, done, converged are 0; iter_count is 0.
  - The first start after reset release is accepted normally.

## Timing
- All outputs are registered. conv_in is the only combinational dependency, through the external `converge` on matrix_out.
- start sampled at edge E0 → LOAD. matrix_out is loaded at E1. CHECK samples conv_in at E2.
- Input already converged: done high in the cycle after E2, i.e. 3 cycles after the start edge.
- Each non-converging iteration adds N³+2 cycles (MAC + WRITE + CHECK).
- Run of k iterations: done 3 + k·(N³+2) cycles after start. For N=2: 3 + 10k.
- busy rises the cycle after E0 and falls together with done.

## Configuration
- MATRIX_SQUARE_SAT_EN defined: the reduced result saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1], i.e. [−32768, 32767].
- MATRIX_SQUARE_SAT_EN undefined: the reduced result is truncated to its low WIDTH bits (two's-complement wrap).
- Rounding is identical in both builds.

## Structure
- Shared package `matrix_pkg` holds:
  - WIDTH and FRAC constants;
  - `fixed_t` typedef (signed WIDTH);
  - the state enum `msq_state_t`.
- One sub-module, `fixed_mac`:
  - multiply-accumulate with clear;
  - round/shift/reduce output stage;
  - holds the MATRIX_SQUARE_SAT_EN logic.
- The top level owns the FSM, the index counters and the A/B register banks.

## Test plan
1. Reset:
   - hold rst_n=0 → matrix_out all 0, busy=0, done=0, converged=0, iter_count=0;
   - assert rst_n mid-MAC of a run → all of the above are 0 immediately, asynchronously;
   - a fresh start afterwards completes normally.
2. Converged input, matrix_in=[[512,512],[512,512]], start:
   - done exactly 3 cycles after the start edge;
   - converged=1, iter_count=0, matrix_out unchanged.
3. Converging input, matrix_in=[[768,256],[256,768]]:
   - matrix_out after each WRITE: [[640,384],[384,640]], [[544,480],[480,544]], [[514,510],[510,514]], [[512,512],[512,512]];
   - done at 43 cycles, converged=1, iter_count=4.
4. Non-converging input, matrix_in=[[1024,0],[0,1024]], with start pulsed again mid-run:
   - the second start is ignored;
   - done at 163 cycles, converged=0, iter_count=16, matrix_out still the identity.
5. Overflow, matrix_in=[[16384,0],[0,16384]]:
   - after the first WRITE, matrix_out[0][0]=32767 with MATRIX_SQUARE_SAT_EN;
   - without the macro, matrix_out[0][0]=0 (262144 wrapped);
   - off-diagonal elements are 0 in both builds.
6. Back-to-back runs: start in the cycle right after done → accepted, converged cleared, new run timed as in scenario 2.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix-squaring engine.
package matrix_pkg;

   localparam int WIDTH = 16;
   localparam int FRAC  = 10;

   typedef logic signed [WIDTH-1:0] fixed_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_MAC,
      ST_WRITE,
      ST_DONE
   } msq_state_t;

endpackage

// File: rtl/fixed_mac.sv
// Signed fixed-point multiply-accumulate with a round/shift/reduce output stage.
// Build option: MATRIX_SQUARE_SAT_EN selects saturation of the reduced result;
// without it the result wraps to its low WIDTH bits.
module fixed_mac import matrix_pkg::*; #(
   parameter int N_TERMS = 2,
   parameter int WIDTH   = matrix_pkg::WIDTH,
   parameter int FRAC    = matrix_pkg::FRAC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);

   localparam int PW    = 2 * WIDTH;
   // One extra bit per doubling of terms keeps the dot product from overflowing.
   localparam int ACC_W = PW + $clog2(N_TERMS);
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);

   logic signed [PW-1:0]    a_ext;
   logic signed [PW-1:0]    b_ext;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;

`ifdef MATRIX_SQUARE_SAT_EN
   localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) <<< (WIDTH - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] MINV = -(ACC_W'(1) <<< (WIDTH - 1));
   logic signed [ACC_W-1:0] rnd;
`endif

   // Product, running sum and the rounded/reduced term that ends a dot product.
   always_comb begin
      a_ext  = PW'($signed(a));
      b_ext  = PW'($signed(b));
      prod   = a_ext * b_ext;
      sum    = acc_q + ACC_W'(prod);
      acc_d  = acc_q;
      if (en) begin
         acc_d = last ? '0 : sum;
      end
`ifdef MATRIX_SQUARE_SAT_EN
      rnd = (sum + HALF) >>> FRAC;
      if (rnd > MAXV) begin
         result = MAXV[WIDTH-1:0];
      end else if (rnd < MINV) begin
         result = MINV[WIDTH-1:0];
      end else begin
         result = rnd[WIDTH-1:0];
      end
`else
      result = WIDTH'((sum + HALF) >>> FRAC);
`endif
   end

   // Accumulator register, cleared after the last term of each dot product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/matrix_square_engine.sv
// Iterative matrix-squaring engine: M, M^2, M^4, ... until the external
// convergence flag is seen or MAX_ITER squarings have been done.
// Build option: MATRIX_SQUARE_SAT_EN (saturating reduction in fixed_mac).
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; outputs hold the last run's result
// LOAD     | copy matrix_in into the working matrix
// CHECK    | sample conv_in / iteration cap, decide DONE or another pass
// MAC      | one product per cycle, i,j,k row-major with k innermost
// WRITE    | working matrix <= B, count the squaring
// DONE     | one-cycle done pulse
module matrix_square_engine import matrix_pkg::*; #(
   parameter int N_STOCKS = 2,
   parameter int WIDTH    = matrix_pkg::WIDTH,
   parameter int FRAC     = matrix_pkg::FRAC,
   parameter int MAX_ITER = 16
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         start,
   input  logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix_in,
   input  logic                                         conv_in,
   output logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix_out,
   output logic                                         busy,
   output logic                                         done,
   output logic                                         converged,
   output logic [$clog2(MAX_ITER+1)-1:0]                iter_count
);

   localparam int IDX_W = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
   localparam int IT_W  = $clog2(MAX_ITER + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STOCKS - 1);
   localparam logic [IT_W-1:0]  ITER_CAP = IT_W'(MAX_ITER);

   typedef logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] bank_t;

   msq_state_t       state_q, state_d;
   bank_t            a_q, a_d;
   bank_t            b_q, b_d;
   logic [IDX_W-1:0] i_q, i_d;
   logic [IDX_W-1:0] j_q, j_d;
   logic [IDX_W-1:0] k_q, k_d;
   logic [IT_W-1:0]  iter_q, iter_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             conv_q, conv_d;
   logic             mac_en;
   logic             mac_last;
   logic [WIDTH-1:0] mac_a;
   logic [WIDTH-1:0] mac_b;
   logic [WIDTH-1:0] mac_result;

   fixed_mac #(
      .N_TERMS (N_STOCKS),
      .WIDTH   (WIDTH),
      .FRAC    (FRAC)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (mac_en),
      .last   (mac_last),
      .a      (mac_a),
      .b      (mac_b),
      .result (mac_result)
   );

   // Next-state, index walk, bank updates and registered-output inputs.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      i_d      = i_q;
      j_d      = j_q;
      k_d      = k_q;
      iter_d   = iter_q;
      conv_d   = conv_q;
      mac_en   = 1'b0;
      mac_last = 1'b0;
      mac_a    = a_q[i_q][k_q];
      mac_b    = a_q[k_q][j_q];

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               conv_d  = 1'b0;
               iter_d  = '0;
            end
         end
         ST_LOAD: begin
            a_d     = matrix_in;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (conv_in) begin
               conv_d  = 1'b1;
               state_d = ST_DONE;
            end else if (iter_q == ITER_CAP) begin
               conv_d  = 1'b0;
               state_d = ST_DONE;
            end else begin
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            mac_en   = 1'b1;
            mac_last = (k_q == IDX_LAST);
            if (mac_last) begin
               b_d[i_q][j_q] = mac_result;
               k_d           = '0;
               if (j_q == IDX_LAST) begin
                  j_d = '0;
                  if (i_q == IDX_LAST) begin
                     i_d     = '0;
                     state_d = ST_WRITE;
                  end else begin
                     i_d = i_q + IDX_W'(1);
                  end
               end else begin
                  j_d = j_q + IDX_W'(1);
               end
            end else begin
               k_d = k_q + IDX_W'(1);
            end
         end
         ST_WRITE: begin
            a_d     = b_q;
            iter_d  = iter_q + IT_W'(1);
            state_d = ST_CHECK;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State, register banks, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         iter_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         conv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         iter_q  <= iter_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         conv_q  <= conv_d;
      end
   end

   assign matrix_out = a_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign converged  = conv_q;
   assign iter_count = iter_q;

endmodule

// File: tb/tb_matrix_square_engine.sv
// Self-checking bench for matrix_square_engine with a row-equality
// convergence stand-in and an integer reference model of the squaring run.
module tb_matrix_square_engine;

   localparam int N    = 2;
   localparam int W    = 16;
   localparam int FR   = 10;
   localparam int MAXI = 16;
   localparam int ITW  = $clog2(MAXI + 1);
   localparam int MAXC = 300;

   typedef logic [N-1:0][N-1:0][W-1:0] pmat_t;
   typedef int mat_t [N][N];

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic           conv_in;
   logic           busy;
   logic           done;
   logic           converged;
   pmat_t          matrix_in;
   pmat_t          matrix_out;
   logic [ITW-1:0] iter_count;

   int    checks = 0;
   int    errors = 0;
   pmat_t snaps  [MAXC];
   logic  busy_s [MAXC];
   logic  conv_s [MAXC];

   matrix_square_engine #(
      .N_STOCKS (N),
      .WIDTH    (W),
      .FRAC     (FR),
      .MAX_ITER (MAXI)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .matrix_in  (matrix_in),
      .conv_in    (conv_in),
      .matrix_out (matrix_out),
      .busy       (busy),
      .done       (done),
      .converged  (converged),
      .iter_count (iter_count)
   );

   always #5 clk = ~clk;

   // Convergence stand-in: all rows identical.
   always_comb begin
      conv_in = 1'b1;
      for (int r = 1; r < N; r++) begin
         if (matrix_out[r] != matrix_out[0]) conv_in = 1'b0;
      end
   end

   function automatic pmat_t mk2(input int a, input int b, input int c, input int d);
      pmat_t r;
      r[0][0] = a[W-1:0];
      r[0][1] = b[W-1:0];
      r[1][0] = c[W-1:0];
      r[1][1] = d[W-1:0];
      return r;
   endfunction

   function automatic pmat_t pack(input mat_t m);
      pmat_t r;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) r[i][j] = m[i][j][W-1:0];
      return r;
   endfunction

   function automatic bit rows_equal(input mat_t m);
      bit eq;
      eq = 1'b1;
      for (int i = 1; i < N; i++)
         for (int j = 0; j < N; j++) if (m[i][j] != m[0][j]) eq = 1'b0;
      return eq;
   endfunction

   // Exact dot products, round half up, then saturate or wrap to W bits.
   function automatic void model_square(input mat_t a, output mat_t r);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            longint s;
            s = 0;
            for (int k = 0; k < N; k++) s += longint'(a[i][k]) * longint'(a[k][j]);
            s = (s + (longint'(1) << (FR - 1))) >>> FR;
`ifdef MATRIX_SQUARE_SAT_EN
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
`else
            s = s & ((longint'(1) << W) - 1);
            if (s >= (longint'(1) << (W - 1))) s -= (longint'(1) << W);
`endif
            r[i][j] = int'(s);
         end
      end
   endfunction

   function automatic void model_run(input mat_t m0, output mat_t fin, output int iters, output bit cv);
      mat_t cur, nxt;
      cur   = m0;
      iters = 0;
      cv    = 1'b0;
      for (int it = 0; it <= MAXI; it++) begin
         iters = it;
         if (rows_equal(cur)) begin
            cv = 1'b1;
            break;
         end
         if (it == MAXI) break;
         model_square(cur, nxt);
         cur = nxt;
      end
      fin = cur;
   endfunction

   // Called just after a falling edge with the DUT idle. Counts rising edges
   // from the start edge (cycle 1 = LOAD) and samples on falling edges.
   // Returns the cycle where done was seen, or -1 on timeout.
   task automatic run_start(input pmat_t m, input int pulse_at, output int dc);
      dc = -1;
      for (int c = 0; c < MAXC; c++) begin
         snaps[c]  = '0;
         busy_s[c] = 1'b0;
         conv_s[c] = 1'b0;
      end
      matrix_in = m;
      start     = 1'b1;
      for (int cyc = 1; cyc < MAXC; cyc++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (cyc >= 2) matrix_in = {$urandom(), $urandom()};
         @(negedge clk);
         snaps[cyc]  = matrix_out;
         busy_s[cyc] = busy;
         conv_s[cyc] = converged;
         if (done === 1'b1) begin
            dc = cyc;
            break;
         end
         start = (cyc == pulse_at);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      int dc;
      rst_n = 1'b0;
      start = 1'b0;
      matrix_in = '0;
      repeat (3) @(negedge clk);
      checks++; if (matrix_out !== '0) begin errors++; $display("FAIL rst_matrix_out: got %h expected 0", matrix_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
      checks++; if (converged !== 1'b0) begin errors++; $display("FAIL rst_converged: got %b expected 0", converged); end
      checks++; if (iter_count !== '0) begin errors++; $display("FAIL rst_iter: got %0d expected 0", iter_count); end
      rst_n = 1'b1;
      @(negedge clk);
      matrix_in = mk2(768, 256, 256, 768);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (matrix_out !== '0) begin errors++; $display("FAIL rst_mid_matrix_out: got %h expected 0", matrix_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      checks++; if (iter_count !== '0) begin errors++; $display("FAIL rst_mid_iter: got %0d expected 0", iter_count); end
      @(negedge clk);
      rst_n = 1'b1;
      run_start(mk2(512, 512, 512, 512), -1, dc);
      checks++; if (dc !== 3) begin errors++; $display("FAIL rst_restart_done_cycle: got %0d expected 3", dc); end
      checks++; if (converged !== 1'b1) begin errors++; $display("FAIL rst_restart_converged: got %b expected 1", converged); end
      @(negedge clk);
   endtask

   task automatic test_converged();
      int dc;
      run_start(mk2(512, 512, 512, 512), -1, dc);
      checks++; if (dc !== 3) begin errors++; $display("FAIL conv_done_cycle: got %0d expected 3", dc); end
      checks++; if (busy_s[1] !== 1'b1) begin errors++; $display("FAIL conv_busy_rise: got %b expected 1", busy_s[1]); end
      checks++; if (converged !== 1'b1) begin errors++; $display("FAIL conv_converged: got %b expected 1", converged); end
      checks++; if (iter_count !== 0) begin errors++; $display("FAIL conv_iter: got %0d expected 0", iter_count); end
      checks++; if (matrix_out !== mk2(512, 512, 512, 512)) begin errors++; $display("FAIL conv_matrix: got %h expected %h", matrix_out, mk2(512, 512, 512, 512)); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL conv_after_done: got done=%b busy=%b expected 0 0", done, busy); end
   endtask

   task automatic test_converging();
      int    dc;
      pmat_t exp_seq [4];
      exp_seq[0] = mk2(640, 384, 384, 640);
      exp_seq[1] = mk2(544, 480, 480, 544);
      exp_seq[2] = mk2(514, 510, 510, 514);
      exp_seq[3] = mk2(512, 512, 512, 512);
      run_start(mk2(768, 256, 256, 768), -1, dc);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (snaps[12 + 10 * k] !== exp_seq[k]) begin
            errors++;
            $display("FAIL converging_write%0d: got %h expected %h", k + 1, snaps[12 + 10 * k], exp_seq[k]);
         end
      end
      checks++; if (dc !== 43) begin errors++; $display("FAIL converging_done_cycle: got %0d expected 43", dc); end
      checks++; if (converged !== 1'b1) begin errors++; $display("FAIL converging_converged: got %b expected 1", converged); end
      checks++; if (iter_count !== 4) begin errors++; $display("FAIL converging_iter: got %0d expected 4", iter_count); end
      @(negedge clk);
   endtask

   task automatic test_cap_and_restart();
      int dc;
      run_start(mk2(1024, 0, 0, 1024), 20, dc);
      checks++; if (dc !== 163) begin errors++; $display("FAIL cap_done_cycle: got %0d expected 163", dc); end
      checks++; if (busy_s[dc > 0 ? dc : 0] !== 1'b1) begin errors++; $display("FAIL cap_busy_at_done: got %b expected 1", busy_s[dc > 0 ? dc : 0]); end
      checks++; if (converged !== 1'b0) begin errors++; $display("FAIL cap_converged: got %b expected 0", converged); end
      checks++; if (iter_count !== 16) begin errors++; $display("FAIL cap_iter: got %0d expected 16", iter_count); end
      checks++; if (matrix_out !== mk2(1024, 0, 0, 1024)) begin errors++; $display("FAIL cap_matrix: got %h expected identity", matrix_out); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cap_idle_after: got busy=%b done=%b expected 0 0", busy, done); end
      checks++; if (matrix_out !== mk2(1024, 0, 0, 1024)) begin errors++; $display("FAIL cap_matrix_held: got %h expected identity", matrix_out); end
   endtask

   task automatic test_overflow();
      int    dc;
      int    exp_diag;
`ifdef MATRIX_SQUARE_SAT_EN
      exp_diag = 32767;
`else
      exp_diag = 0;
`endif
      run_start(mk2(16384, 0, 0, 16384), -1, dc);
      checks++; if ($signed(snaps[12][0][0]) !== exp_diag) begin errors++; $display("FAIL overflow_diag00: got %0d expected %0d", $signed(snaps[12][0][0]), exp_diag); end
      checks++; if ($signed(snaps[12][1][1]) !== exp_diag) begin errors++; $display("FAIL overflow_diag11: got %0d expected %0d", $signed(snaps[12][1][1]), exp_diag); end
      checks++; if (snaps[12][0][1] !== '0 || snaps[12][1][0] !== '0) begin errors++; $display("FAIL overflow_offdiag: got %h %h expected 0 0", snaps[12][0][1], snaps[12][1][0]); end
      checks++; if (dc < 0) begin errors++; $display("FAIL overflow_timeout: got %0d expected a done cycle", dc); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int dc1, dc2;
      run_start(mk2(512, 512, 512, 512), -1, dc1);
      @(posedge clk);
      @(negedge clk);
      run_start(mk2(300, 724, 300, 724), -1, dc2);
      checks++; if (dc1 !== 3 || dc2 !== 3) begin errors++; $display("FAIL b2b_done_cycles: got %0d %0d expected 3 3", dc1, dc2); end
      checks++; if (conv_s[1] !== 1'b0) begin errors++; $display("FAIL b2b_converged_cleared: got %b expected 0", conv_s[1]); end
      checks++; if (converged !== 1'b1) begin errors++; $display("FAIL b2b_converged: got %b expected 1", converged); end
      checks++; if (matrix_out !== mk2(300, 724, 300, 724)) begin errors++; $display("FAIL b2b_matrix: got %h expected %h", matrix_out, mk2(300, 724, 300, 724)); end
      @(negedge clk);
   endtask

   task automatic test_random();
      mat_t  m0, fin;
      int    iters, dc, p, q;
      bit    cv;
      for (int t = 0; t < 8; t++) begin
         if (t % 2 == 0) begin
            p = int'($urandom_range(1024));
            q = int'($urandom_range(1024));
            m0[0][0] = p;  m0[0][1] = 1024 - p;
            m0[1][0] = q;  m0[1][1] = 1024 - q;
         end else begin
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) m0[i][j] = int'($urandom_range(4096)) - 2048;
         end
         model_run(m0, fin, iters, cv);
         run_start(pack(m0), -1, dc);
         checks++; if (dc !== 3 + 10 * iters) begin errors++; $display("FAIL rand%0d_done_cycle: got %0d expected %0d", t, dc, 3 + 10 * iters); end
         checks++; if (iter_count !== ITW'(iters)) begin errors++; $display("FAIL rand%0d_iter: got %0d expected %0d", t, iter_count, iters); end
         checks++; if (converged !== cv) begin errors++; $display("FAIL rand%0d_converged: got %b expected %b", t, converged, cv); end
         checks++; if (matrix_out !== pack(fin)) begin errors++; $display("FAIL rand%0d_matrix: got %h expected %h", t, matrix_out, pack(fin)); end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_converged();
      test_converging();
      test_cap_and_restart();
      test_overflow();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
